// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

    // Active scan slots; the name carries the digit index
    typedef enum logic [2:0] {S0, S2, S3, S4, S6} slot_e;

    // One-cold digit enables, active-low anodes
    localparam logic [7:0] DSEL_S0   = 8'hFE;
    localparam logic [7:0] DSEL_S2   = 8'hFB;
    localparam logic [7:0] DSEL_S3   = 8'hF7;
    localparam logic [7:0] DSEL_S4   = 8'hEF;
    localparam logic [7:0] DSEL_S6   = 8'hBF;
    localparam logic [7:0] DSEL_OFF  = 8'hFF;

    localparam logic [6:0] BLANK_SEG    = 7'h7F;
    localparam logic [3:0] BLANK_CODE   = 4'hF;
    localparam logic [1:0] GAME_RUNNING = 2'b00;

    // Values frozen for the visible part of a slot
    typedef struct packed {
        logic [2:0] t5;
        logic [4:0] t30;
        logic [1:0] level;
        logic [1:0] life;
        logic       phase;   // 1 = flash off-phase
    } snap_t;

    function automatic slot_e slot_next(input slot_e s);
        case (s)
            S0:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S6;
            default: return S0;
        endcase
    endfunction

    function automatic logic [7:0] slot_dsel(input slot_e s);
        case (s)
            S0:      return DSEL_S0;
            S2:      return DSEL_S2;
            S3:      return DSEL_S3;
            S4:      return DSEL_S4;
            S6:      return DSEL_S6;
            default: return DSEL_OFF;
        endcase
    endfunction

    // Tens digit of a 0..31 value by threshold compare (no divider)
    function automatic logic [1:0] bcd_tens(input logic [4:0] v);
        if (v >= 5'd30)      return 2'd3;
        else if (v >= 5'd20) return 2'd2;
        else if (v >= 5'd10) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [3:0] bcd_units(input logic [4:0] v);
        case (bcd_tens(v))
            2'd3:    return 4'(v - 5'd30);
            2'd2:    return 4'(v - 5'd20);
            2'd1:    return 4'(v - 5'd10);
            default: return 4'(v);
        endcase
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex code to active-low seven-segment pattern (bit0 = a .. bit6 = g).
// Code F is used as the blank code rather than a glyph.
module seg_hex_decoder
    import disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Glyph lookup
    always_comb begin
        o_seg = BLANK_SEG;
        case (i_code)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            default: o_seg = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of the game status digits onto the 8-digit display.
// Each slot starts with a blank interval; at its end the inputs are
// snapshotted and the one shared decoder drives the registered segments.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int FLASH_DIV    = 50000000
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic [2:0] timer_5,
    input  logic [4:0] timer_30,
    input  logic [1:0] level,
    input  logic [1:0] life,
    input  logic [1:0] game_end,
    output logic [6:0] seven,
    output logic [7:0] digit_select
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [CW-1:0] r_cnt;
    slot_e         r_slot;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    snap_t         r_snap;
    logic [6:0]    r_seven;
    logic [7:0]    r_dsel;

    logic          w_snap_edge;
    logic          w_slot_end;
    logic          w_hold;
    snap_t         w_live;
    snap_t         w_src;
    logic [1:0]    w_tens;
    logic [3:0]    w_units;
    logic [3:0]    w_code;
    logic          w_en;
    logic [7:0]    w_dsel;
    logic [6:0]    w_seg;

    assign w_slot_end  = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_snap_edge = (r_cnt == CW'(BLANK_CYCLES - 1));
    assign w_hold      = (r_cnt > CW'(BLANK_CYCLES - 1));

    // On the snapshot edge decode straight from the inputs being captured;
    // afterwards keep decoding from the frozen copy so the digit cannot move.
    assign w_live  = {timer_5, timer_30, level, life, r_phase};
    assign w_src   = w_snap_edge ? w_live : r_snap;
    assign w_tens  = bcd_tens(w_src.t30);
    assign w_units = bcd_units(w_src.t30);

    // Slot content select, leading-zero and flash suppression
    always_comb begin
        w_code = BLANK_CODE;
        w_en   = 1'b1;
        case (r_slot)
            S0: w_code = {1'b0, w_src.t5};
            S2: w_code = w_units;
            S3: begin
                w_code = {2'b00, w_tens};
                if (w_tens == 2'd0) w_en = 1'b0;
            end
            S4: w_code = {2'b00, w_src.life};
            S6: w_code = {2'b00, w_src.level} + 4'd1;
            default: w_en = 1'b0;
        endcase
        if (w_src.phase && (r_slot == S0 || r_slot == S2 || r_slot == S3))
            w_en = 1'b0;
        if (!w_en)
            w_code = BLANK_CODE;
        w_dsel = w_en ? slot_dsel(r_slot) : DSEL_OFF;
    end

    seg_hex_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // Slot timer and slot sequencing
    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_slot <= S0;
        end else if (w_slot_end) begin
            r_cnt  <= '0;
            r_slot <= slot_next(r_slot);
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Flash half-period timer; held clear while the game is running
    always_ff @(posedge in_clk) begin
        if (reset || game_end == GAME_RUNNING) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_fcnt == FW'(FLASH_DIV - 1)) begin
            r_fcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_fcnt  <= r_fcnt + FW'(1);
        end
    end

    // Capture the displayed values once per slot
    always_ff @(posedge in_clk) begin
        if (reset)
            r_snap <= '0;
        else if (w_snap_edge)
            r_snap <= w_live;
    end

    // Registered segment/anode drive: blank at slot end, load at snapshot
    always_ff @(posedge in_clk) begin
        if (reset || w_slot_end) begin
            r_seven <= BLANK_SEG;
            r_dsel  <= DSEL_OFF;
        end else if (w_snap_edge || w_hold) begin
            r_seven <= w_seg;
            r_dsel  <= w_dsel;
        end
    end

    assign seven        = r_seven;
    assign digit_select = r_dsel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: one table record per scan slot, starting right after
// reset release, with expected anode/segment values worked out by hand.
module tb_display_scan_ctrl;

    logic       in_clk;
    logic       reset;
    logic [2:0] timer_5;
    logic [4:0] timer_30;
    logic [1:0] level;
    logic [1:0] life;
    logic [1:0] game_end;
    logic [6:0] seven;
    logic [7:0] digit_select;

    int n_vec = 0;
    int n_err = 0;

    display_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .FLASH_DIV    (20)
    ) dut (
        .in_clk       (in_clk),
        .reset        (reset),
        .timer_5      (timer_5),
        .timer_30     (timer_30),
        .level        (level),
        .life         (life),
        .game_end     (game_end),
        .seven        (seven),
        .digit_select (digit_select)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    typedef struct {
        logic [2:0] t5;
        logic [4:0] t30;
        logic [1:0] lv;
        logic [1:0] life;
        logic [1:0] life_mid;  // life value driven from mid-slot on
        logic [1:0] ge;
        logic [7:0] sel;
        logic [6:0] seg;
    } vec_t;

    localparam int NV = 37;
    vec_t tbl [NV];

    function automatic vec_t mk(int t5, int t30, int lv, int lf, int mid, int ge, int sel, int seg);
        vec_t v;
        v.t5 = 3'(t5); v.t30 = 5'(t30); v.lv = 2'(lv); v.life = 2'(lf);
        v.life_mid = 2'(mid); v.ge = 2'(ge); v.sel = 8'(sel); v.seg = 7'(seg);
        return v;
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check(string name, logic [7:0] sel, logic [6:0] seg);
        n_vec++;
        if (digit_select !== sel || seven !== seg) begin
            n_err++;
            $display("FAIL %s: digit_select=%h seven=%h, expected %h %h",
                     name, digit_select, seven, sel, seg);
        end
    endtask

    // One full slot from its first blank cycle to the next slot's start
    task automatic run_slot(string tag, vec_t v);
        timer_5 = v.t5; timer_30 = v.t30; level = v.lv; life = v.life; game_end = v.ge;
        for (int c = 0; c < 8; c++) begin
            if (c < 2) check($sformatf("%s c%0d", tag, c), 8'hFF, 7'h7F);
            else       check($sformatf("%s c%0d", tag, c), v.sel, v.seg);
            if (c == 4) life = v.life_mid;
            tick();
        end
    endtask

    initial begin
        // slot order: S0 S2 S3 S4 S6
        tbl[0]  = mk(3, 25, 3, 1, 1, 0, 'hFE, 'h30);  // '3'
        tbl[1]  = mk(3, 25, 3, 1, 1, 0, 'hFB, 'h12);  // units '5'
        tbl[2]  = mk(3, 25, 3, 1, 1, 0, 'hF7, 'h24);  // tens '2'
        tbl[3]  = mk(3, 25, 3, 1, 1, 0, 'hEF, 'h79);  // life '1'
        tbl[4]  = mk(3, 25, 3, 1, 1, 0, 'hBF, 'h19);  // level 3 -> '4'
        tbl[5]  = mk(7, 7, 0, 2, 2, 0, 'hFE, 'h78);
        tbl[6]  = mk(7, 7, 0, 2, 2, 0, 'hFB, 'h78);
        tbl[7]  = mk(7, 7, 0, 2, 2, 0, 'hFF, 'h7F);   // leading zero
        tbl[8]  = mk(7, 7, 0, 3, 3, 0, 'hEF, 'h30);
        tbl[9]  = mk(7, 7, 0, 3, 3, 0, 'hBF, 'h79);
        tbl[10] = mk(0, 30, 1, 0, 0, 0, 'hFE, 'h40);
        tbl[11] = mk(0, 30, 1, 0, 0, 0, 'hFB, 'h40);
        tbl[12] = mk(0, 30, 1, 0, 0, 0, 'hF7, 'h30);
        tbl[13] = mk(0, 30, 1, 0, 0, 0, 'hEF, 'h40);
        tbl[14] = mk(0, 30, 1, 0, 0, 0, 'hBF, 'h24);
        tbl[15] = mk(5, 25, 1, 1, 1, 0, 'hFE, 'h12);
        tbl[16] = mk(5, 25, 1, 1, 1, 0, 'hFB, 'h12);
        tbl[17] = mk(5, 25, 1, 1, 1, 0, 'hF7, 'h24);
        tbl[18] = mk(5, 25, 1, 1, 2, 0, 'hEF, 'h79);  // life changes mid-slot
        tbl[19] = mk(5, 25, 1, 2, 2, 0, 'hBF, 'h24);
        tbl[20] = mk(5, 25, 1, 2, 2, 0, 'hFE, 'h12);
        tbl[21] = mk(5, 25, 1, 2, 2, 0, 'hFB, 'h12);
        tbl[22] = mk(5, 25, 1, 2, 2, 0, 'hF7, 'h24);
        // game ends at the start of this S4; phase toggles 20, 40, 60 edges later
        tbl[23] = mk(5, 25, 1, 2, 2, 2, 'hEF, 'h24);  // next S4 shows new life
        tbl[24] = mk(5, 25, 1, 2, 2, 2, 'hBF, 'h24);
        tbl[25] = mk(5, 25, 1, 2, 2, 2, 'hFE, 'h12);  // snap edge 18: on
        tbl[26] = mk(5, 25, 1, 2, 2, 2, 'hFF, 'h7F);  // snap edge 26: off
        tbl[27] = mk(5, 25, 1, 2, 2, 2, 'hFF, 'h7F);  // snap edge 34: off
        tbl[28] = mk(5, 25, 1, 2, 2, 2, 'hEF, 'h24);  // S4 steady
        tbl[29] = mk(5, 25, 1, 2, 2, 2, 'hBF, 'h24);  // S6 steady
        tbl[30] = mk(5, 25, 1, 2, 2, 2, 'hFE, 'h12);  // snap edge 58: on
        tbl[31] = mk(5, 25, 1, 2, 2, 2, 'hFF, 'h7F);  // snap edge 66: off
        tbl[32] = mk(5, 25, 1, 2, 2, 0, 'hF7, 'h24);  // game resumes: visible
        tbl[33] = mk(5, 25, 1, 2, 2, 0, 'hEF, 'h24);
        tbl[34] = mk(5, 25, 1, 2, 2, 0, 'hBF, 'h24);
        tbl[35] = mk(5, 25, 1, 2, 2, 0, 'hFE, 'h12);
        tbl[36] = mk(5, 25, 1, 2, 2, 0, 'hFB, 'h12);

        // reset state
        reset = 1'b1;
        timer_5 = 3'd3; timer_30 = 5'd25; level = 2'd3; life = 2'd1; game_end = 2'd0;
        tick();
        check("reset c0", 8'hFF, 7'h7F);
        tick();
        tick();
        check("reset c2", 8'hFF, 7'h7F);
        reset = 1'b0;

        // table: each record is one consecutive slot after reset release
        for (int i = 0; i < NV; i++)
            run_slot($sformatf("slot%0d", i), tbl[i]);

        // reset in the middle of S3 (slot 37 is S3)
        for (int c = 0; c < 4; c++) begin
            if (c < 2) check($sformatf("pre_rst c%0d", c), 8'hFF, 7'h7F);
            else       check($sformatf("pre_rst c%0d", c), 8'hF7, 7'h24);
            tick();
        end
        check("pre_rst c4", 8'hF7, 7'h24);
        reset = 1'b1;
        tick();
        check("rst_mid edge1", 8'hFF, 7'h7F);
        tick();
        check("rst_mid edge2", 8'hFF, 7'h7F);
        reset = 1'b0;
        run_slot("after_rst S0", tbl[35]);
        run_slot("after_rst S2", tbl[36]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
